// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// instr_encoder_if : field-bundle input and encoded-word output bus of instr_encoder
// Rev 1.0
// ============================================================================
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned ERR_W  = 8
) ();

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        fmt;
  logic [3:0]        aluop;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       komut;
  logic [ADDR_W-1:0] waddr;
  logic              out_last;
  logic              hata;
  logic [ERR_W-1:0]  err_count;
  logic              busy;
  logic              done;

  modport slave (
    input  start, in_valid, in_last, fmt, aluop, rs1, rs2, rd, imm, out_ready,
    output in_ready, out_valid, komut, waddr, out_last, hata, err_count, busy, done
  );

  modport master (
    output start, in_valid, in_last, fmt, aluop, rs1, rs2, rd, imm, out_ready,
    input  in_ready, out_valid, komut, waddr, out_last, hata, err_count, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : encodes R/I/U/B field bundles into komut words for program memory
// Rev 1.0
// ============================================================================
module instr_encoder #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ERR_W     = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  instr_encoder_if.slave    bus
);

  localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  C_ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0]  C_ERR_MAX  = '1;

  localparam logic [1:0] C_FMT_R = 2'd0;
  localparam logic [1:0] C_FMT_I = 2'd1;
  localparam logic [1:0] C_FMT_U = 2'd2;

  localparam logic [6:0] C_OP_R = 7'b0000001;
  localparam logic [6:0] C_OP_I = 7'b0000011;
  localparam logic [6:0] C_OP_U = 7'b0000111;
  localparam logic [6:0] C_OP_B = 7'b0001111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       komut_q,     komut_d;
  logic [ADDR_W-1:0] waddr_q,     waddr_d;
  logic              out_last_q,  out_last_d;
  logic              hata_q,      hata_d;
  logic [ERR_W-1:0]  err_q,       err_d;
  logic              done_q,      done_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        in_ready;
  logic        in_acc;
  logic        out_acc;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.fmt)
      C_FMT_R: begin
        enc_word = {1'b0, bus.aluop[3], 5'b0, bus.rs2, bus.rs1,
                    bus.aluop[2:0], bus.rd, C_OP_R};
      end
      C_FMT_I: begin
        enc_word  = {bus.imm[11:0], bus.rs1, bus.aluop[2:0], bus.rd, C_OP_I};
        enc_legal = !bus.aluop[3] && (bus.imm[31:12] == '0);
      end
      C_FMT_U: begin
        enc_word  = {bus.imm[19:0], bus.rd, C_OP_U};
        enc_legal = (bus.imm[31:20] == '0);
      end
      default: begin
        // Branch offsets are halfword aligned, so imm[0] never reaches the word
        enc_word  = {bus.imm[12:6], bus.rs2, bus.rs1, bus.aluop[2:0],
                     bus.imm[5:1], C_OP_B};
        enc_legal = !bus.imm[0] && (bus.imm[31:13] == '0) && !bus.aluop[3];
      end
    endcase
  end

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign in_acc   = bus.in_valid && in_ready;
  assign out_acc  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    komut_d     = komut_q;
    waddr_d     = waddr_q;
    out_last_d  = out_last_q;
    hata_d      = 1'b0;
    err_d       = err_q;
    done_d      = 1'b0;

    if (out_acc) begin
      out_valid_d = 1'b0;
      waddr_d     = waddr_q + C_ADDR_ONE;
    end

    // An accept implies the register is empty or draining this cycle
    if (in_acc) begin
      if (enc_legal) begin
        out_valid_d = 1'b1;
        komut_d     = enc_word;
        out_last_d  = bus.in_last;
      end else begin
        hata_d = 1'b1;
        if (err_q != C_ERR_MAX) begin
          err_d = err_q + C_ERR_ONE;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          waddr_d = C_BASE;
          err_d   = '0;
        end
      end
      S_RUN: begin
        if (in_acc && bus.in_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_acc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      komut_q     <= '0;
      waddr_q     <= C_BASE;
      out_last_q  <= 1'b0;
      hata_q      <= 1'b0;
      err_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      komut_q     <= komut_d;
      waddr_q     <= waddr_d;
      out_last_q  <= out_last_d;
      hata_q      <= hata_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.komut     = komut_q;
  assign bus.waddr     = waddr_q;
  assign bus.out_last  = out_last_q;
  assign bus.hata      = hata_q;
  assign bus.err_count = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_instr_encoder : directed and randomized checks of instr_encoder against a field-level model
// Rev 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 0;
  localparam int ERR_W     = 3;
  localparam int ADDR_MOD  = 1 << ADDR_W;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

  instr_encoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .ERR_W    (ERR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  // Words accepted on the input side but not yet taken by memory
  exp_t q[$];
  int   m_phase;   // 0 idle, 1 loading, 2 waiting for the last word to leave
  int   m_waddr;
  int   m_err;
  bit   exp_hata;
  bit   exp_done;

  function automatic void ref_encode(input int fmt, input int aluop, input int rs1,
                                     input int rs2, input int rd, input logic [31:0] imm_v,
                                     output bit legal, output logic [31:0] word);
    longint imm = longint'(imm_v);
    longint w;
    case (fmt)
      0: begin
        legal = 1;
        w = 1 + rd * 128 + (aluop % 8) * 4096 + rs1 * 32768 + rs2 * (1 << 20)
            + (aluop / 8) * (1 << 30);
      end
      1: begin
        legal = (aluop < 8) && (imm < 4096);
        w = 3 + rd * 128 + (aluop % 8) * 4096 + rs1 * 32768 + (imm % 4096) * (1 << 20);
      end
      2: begin
        legal = (imm < (1 << 20));
        w = 7 + rd * 128 + (imm % (1 << 20)) * 4096;
      end
      default: begin
        legal = (imm % 2 == 0) && (imm < 8192) && (aluop < 8);
        w = 15 + ((imm / 2) % 32) * 128 + (aluop % 8) * 4096 + rs1 * 32768
            + rs2 * (1 << 20) + ((imm / 64) % 128) * (1 << 25);
      end
    endcase
    word = w[31:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase  = 0;
    m_waddr  = BASE_ADDR;
    m_err    = 0;
    exp_hata = 0;
    exp_done = 0;
  endtask

  // One clock: compare outputs with the model, advance the model, wait for the next negedge
  task automatic tick(output bit acc);
    bit          ir, oacc, legal, hn, dn;
    int          ph;
    logic [31:0] w;
    exp_t        e;
    #1;
    ph = m_phase;
    ir = (ph == 1) && (q.size() == 0 || bus.out_ready);
    check_eq("in_ready",  32'(bus.in_ready),  32'(ir));
    check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check_eq("busy",      32'(bus.busy),      32'(ph != 0));
    check_eq("hata",      32'(bus.hata),      32'(exp_hata));
    check_eq("done",      32'(bus.done),      32'(exp_done));
    check_eq("err_count", 32'(bus.err_count), 32'(m_err));
    if (q.size() != 0) begin
      check_eq("komut",    bus.komut,          q[0].word);
      check_eq("waddr",    32'(bus.waddr),     q[0].addr);
      check_eq("out_last", 32'(bus.out_last),  32'(q[0].last));
    end
    acc  = 0;
    hn   = 0;
    dn   = 0;
    oacc = (q.size() != 0) && bus.out_ready;
    if (reset) begin
      q.delete();
      m_phase = 0;
      m_waddr = BASE_ADDR;
      m_err   = 0;
    end else begin
      acc = bus.in_valid && ir;
      if (ph == 2 && (q.size() == 0 || oacc)) begin
        m_phase = 0;
        dn      = 1;
      end
      if (oacc) begin
        void'(q.pop_front());
        m_waddr = (m_waddr + 1) % ADDR_MOD;
      end
      if (acc) begin
        ref_encode(int'(bus.fmt), int'(bus.aluop), int'(bus.rs1), int'(bus.rs2),
                   int'(bus.rd), bus.imm, legal, w);
        if (legal) begin
          e.word = w;
          e.addr = 32'(m_waddr);
          e.last = bus.in_last;
          q.push_back(e);
        end else begin
          hn = 1;
          if (m_err < ERR_MAX) m_err++;
        end
        if (bus.in_last) m_phase = 2;
      end else if (ph == 0 && bus.start) begin
        m_phase = 1;
        m_waddr = BASE_ADDR;
        m_err   = 0;
      end
    end
    @(posedge clk);
    exp_hata = hn;
    exp_done = dn;
    @(negedge clk);
  endtask

  task automatic start_session();
    bit acc;
    bus.start = 1'b1;
    tick(acc);
    bus.start = 1'b0;
  endtask

  task automatic send(input int fmt, input int aluop, input int rs1, input int rs2,
                      input int rd, input logic [31:0] imm, input bit last);
    bit acc = 0;
    bus.fmt      = 2'(fmt);
    bus.aluop    = 4'(aluop);
    bus.rs1      = 5'(rs1);
    bus.rs2      = 5'(rs2);
    bus.rd       = 5'(rd);
    bus.imm      = imm;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic finish_session();
    bit acc;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && m_phase != 0; i++) tick(acc);
    if (m_phase != 0) check_eq("drain_timeout", 32'd0, 32'd1);
    tick(acc);
    tick(acc);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 4095));
      1: return 32'($urandom_range(0, (1 << 20) - 1));
      2: return 32'($urandom_range(0, 8191));
      3: return $urandom();
      4: begin
        logic [31:0] edges [6] = '{32'hFFF, 32'h1000, 32'hFFFFF, 32'h100000, 32'h1FFE, 32'h2000};
        return edges[$urandom_range(0, 5)];
      end
      default: return 32'($urandom_range(0, 8191)) & 32'h1FFE;
    endcase
  endfunction

  task automatic random_session();
    int n;
    bit acc;
    logic [31:0] imm;
    int fmt, aluop;
    start_session();
    n = $urandom_range(1, 12);
    for (int k = 0; k < n; k++) begin
      fmt   = $urandom_range(0, 3);
      aluop = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 7) : $urandom_range(8, 15);
      imm   = rand_imm();
      bus.fmt     = 2'(fmt);
      bus.aluop   = 4'(aluop);
      bus.rs1     = 5'($urandom_range(0, 31));
      bus.rs2     = 5'($urandom_range(0, 31));
      bus.rd      = 5'($urandom_range(0, 31));
      bus.imm     = imm;
      bus.in_last = (k == n - 1);
      acc = 0;
      for (int c = 0; c < 60 && !acc; c++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.start     = ($urandom_range(0, 9) == 0);
        tick(acc);
      end
      if (!acc) check_eq("rand_send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.start    = 1'b0;
    end
    finish_session();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] wrap_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.fmt       = '0;
    bus.aluop     = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.rd        = '0;
    bus.imm       = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_komut",     bus.komut,          32'd0);
    check_eq("rst_waddr",     32'(bus.waddr),     32'(BASE_ADDR));
    check_eq("rst_out_last",  32'(bus.out_last),  32'd0);
    check_eq("rst_hata",      32'(bus.hata),      32'd0);
    check_eq("rst_err",       32'(bus.err_count), 32'd0);
    check_eq("rst_done",      32'(bus.done),      32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    reset = 1'b0;
    tick(acc);

    // R word
    start_session();
    bus.out_ready = 1'b1;
    send(0, 8, 1, 2, 3, 32'h0, 1'b1);
    check_eq("r_komut", bus.komut, 32'h40208181);
    check_eq("r_waddr", 32'(bus.waddr), 32'd0);
    check_eq("r_valid", 32'(bus.out_valid), 32'd1);
    finish_session();

    // I word under back-pressure, then two illegal bundles
    start_session();
    bus.out_ready = 1'b0;
    send(1, 2, 6, 0, 5, 32'h7FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check_eq("i_hold_komut", bus.komut, 32'h7FF32283);
      check_eq("i_hold_ready", 32'(bus.in_ready), 32'd0);
      check_eq("i_hold_waddr", 32'(bus.waddr), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick(acc);
    send(3, 0, 0, 0, 0, 32'h3, 1'b0);
    check_eq("ill_b_hata",  32'(bus.hata),      32'd1);
    check_eq("ill_b_valid", 32'(bus.out_valid), 32'd0);
    check_eq("ill_b_err",   32'(bus.err_count), 32'd1);
    check_eq("ill_b_waddr", 32'(bus.waddr),     32'd1);
    send(1, 9, 1, 1, 1, 32'h0, 1'b1);
    check_eq("ill_i_err",   32'(bus.err_count), 32'd2);
    finish_session();

    // U then B back to back
    start_session();
    bus.out_ready = 1'b1;
    send(2, 0, 0, 0, 1, 32'h000ABCDE, 1'b0);
    check_eq("u_komut", bus.komut, 32'hABCDE087);
    check_eq("u_waddr", 32'(bus.waddr), 32'd0);
    send(3, 0, 1, 2, 0, 32'h1FFE, 1'b1);
    check_eq("b_komut", bus.komut, 32'hFE208F8F);
    check_eq("b_waddr", 32'(bus.waddr), 32'd1);
    check_eq("b_last",  32'(bus.out_last), 32'd1);
    finish_session();
    check_eq("ub_busy", 32'(bus.busy), 32'd0);

    // Address wrap
    start_session();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(0, i, i, i, i, 32'h0, i == 4);
      check_eq("wrap_waddr", 32'(bus.waddr), wrap_exp[i]);
    end
    finish_session();

    // Error counter saturation
    start_session();
    for (int i = 0; i < 9; i++) send(2, 0, 0, 0, 0, 32'h100000, i == 8);
    check_eq("err_sat", 32'(bus.err_count), 32'(ERR_MAX));
    finish_session();

    // Reset while a word is held
    start_session();
    bus.out_ready = 1'b0;
    send(0, 1, 2, 3, 4, 32'h0, 1'b0);
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    tick(acc);
    reset = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_busy",  32'(bus.busy),      32'd0);
    check_eq("mid_rst_err",   32'(bus.err_count), 32'd0);
    check_eq("mid_rst_komut", bus.komut,          32'd0);
    tick(acc);
    tick(acc);

    for (int s = 0; s < 40; s++) random_session();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
